// File: rtl/seq_signed_divider_pkg.sv
// Shared types and constants for the sequential signed divider.
package seq_signed_divider_pkg;
  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } div_state_e;

  // Counter must reach 2*w iterations.
  function automatic int cnt_width(input int w);
    return $clog2(2 * w + 1);
  endfunction

  localparam int DEF_CNT_W = cnt_width(DEF_WIDTH);
endpackage

// File: rtl/seq_signed_divider_if.sv
// Operand/result bundle for the sequential signed divider.
interface seq_signed_divider_if #(
  parameter int WIDTH = seq_signed_divider_pkg::DEF_WIDTH
);
  // Handshake: start is sampled only while idle (busy=0); busy stays high from
  // the accepting edge until results land, and done pulses one cycle with results.
  logic                 start;
  logic [2*WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]     divisor;
  logic                 busy;
  logic                 done;
  logic [WIDTH-1:0]     quotient;
  logic [WIDTH-1:0]     remainder;
  logic                 ovf;
  logic                 dbz;
  logic [1:0]           state;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, ovf, dbz, state
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, ovf, dbz, state
  );
endinterface

// File: rtl/seq_signed_divider_div_step.sv
// One restoring shift-subtract iteration on unsigned magnitudes.
module seq_signed_divider_div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   prem,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] dsr_mag,
  output logic [WIDTH:0]   prem_next,
  output logic             q_bit
);
  logic [WIDTH:0] shifted;

  always_comb begin
    shifted = {prem[WIDTH-1:0], dvd_bit};
    // A set MSB shifted out means the true value already exceeds any divisor;
    // the modular subtract below still yields the right remainder.
    q_bit     = prem[WIDTH] | (shifted >= {1'b0, dsr_mag});
    prem_next = q_bit ? (shifted - {1'b0, dsr_mag}) : shifted;
  end
endmodule

// File: rtl/seq_signed_divider.sv
// Sequential signed divider: 2W-bit dividend / W-bit divisor, fixed 2W+1 latency.
module seq_signed_divider
  import seq_signed_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic                 clk,
  input logic                 rst,
  seq_signed_divider_if.slave bus
);
  localparam int CW = cnt_width(WIDTH);
  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] CALC = ST_CALC;
  localparam logic [1:0] FIX  = ST_FIX;
  localparam logic [CW-1:0] LAST = CW'(2 * WIDTH - 1);
  localparam logic [2*WIDTH-1:0] Q_POS_MAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [2*WIDTH-1:0] Q_NEG_MAX = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] dvd_sh;
  logic [WIDTH-1:0]   dsr_mag;
  logic [WIDTH:0]     prem;
  logic [2*WIDTH-1:0] qacc;
  logic               neg_q, neg_r, dsr_zero;
  logic               busy_r, done_r, ovf_r, dbz_r;
  logic [WIDTH-1:0]   quot_r, rem_r;

  logic [2*WIDTH-1:0] dvd_mag_in;
  logic [WIDTH-1:0]   dsr_mag_in;
  logic [WIDTH:0]     prem_next;
  logic               q_bit;
  logic [WIDTH-1:0]   quot_signed, rem_signed;
  logic               q_ovf;

  always_comb begin
    dvd_mag_in  = bus.dividend[2*WIDTH-1] ? -bus.dividend : bus.dividend;
    dsr_mag_in  = bus.divisor[WIDTH-1] ? -bus.divisor : bus.divisor;
    // Low W bits of the negated magnitude equal the negation of its low W bits.
    quot_signed = neg_q ? -qacc[WIDTH-1:0] : qacc[WIDTH-1:0];
    rem_signed  = neg_r ? -prem[WIDTH-1:0] : prem[WIDTH-1:0];
    q_ovf       = neg_q ? (qacc > Q_NEG_MAX) : (qacc > Q_POS_MAX);
  end

  seq_signed_divider_div_step #(.WIDTH(WIDTH)) u_step (
    .prem      (prem),
    .dvd_bit   (dvd_sh[2*WIDTH-1]),
    .dsr_mag   (dsr_mag),
    .prem_next (prem_next),
    .q_bit     (q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      dvd_sh   <= '0;
      dsr_mag  <= '0;
      prem     <= '0;
      qacc     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dsr_zero <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      quot_r   <= '0;
      rem_r    <= '0;
      ovf_r    <= 1'b0;
      dbz_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            dvd_sh   <= dvd_mag_in;
            dsr_mag  <= dsr_mag_in;
            prem     <= '0;
            qacc     <= '0;
            cnt      <= '0;
            neg_q    <= bus.dividend[2*WIDTH-1] ^ bus.divisor[WIDTH-1];
            neg_r    <= bus.dividend[2*WIDTH-1];
            dsr_zero <= (bus.divisor == '0);
            busy_r   <= 1'b1;
            state    <= CALC;
          end
        end
        CALC: begin
          prem   <= prem_next;
          dvd_sh <= {dvd_sh[2*WIDTH-2:0], 1'b0};
          qacc   <= {qacc[2*WIDTH-2:0], q_bit};
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          if (dsr_zero) begin
            quot_r <= '0;
            rem_r  <= '0;
            ovf_r  <= 1'b0;
            dbz_r  <= 1'b1;
          end else begin
            quot_r <= quot_signed;
            rem_r  <= rem_signed;
            ovf_r  <= q_ovf;
            dbz_r  <= 1'b0;
          end
          done_r <= 1'b1;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.quotient  = quot_r;
  assign bus.remainder = rem_r;
  assign bus.ovf       = ovf_r;
  assign bus.dbz       = dbz_r;
  assign bus.state     = state;
endmodule

// File: tb/tb_seq_signed_divider.sv
// Self-checking bench for seq_signed_divider against an integer-arithmetic model.
module tb_seq_signed_divider;
  localparam int W = 4;
  localparam int LAT = 2 * W + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  seq_signed_divider_if #(.WIDTH(W)) bus ();

  seq_signed_divider #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard
  logic [W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: plain signed division, truncating toward zero.
  task automatic ref_model(input logic [2*W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] q, output logic [W-1:0] r,
                           output logic ovf, output logic dbz);
    int ai, bi, tq, tr;
    ai = int'($signed(a));
    bi = int'($signed(b));
    if (bi == 0) begin
      q = '0; r = '0; ovf = 1'b0; dbz = 1'b1;
    end else begin
      tq  = ai / bi;
      tr  = ai % bi;
      q   = tq[W-1:0];
      r   = tr[W-1:0];
      ovf = (tq > (2 ** (W - 1)) - 1) || (tq < -(2 ** (W - 1)));
      dbz = 1'b0;
    end
  endtask

  // Driver tasks
  task automatic launch(input logic [2*W-1:0] a, input logic [W-1:0] b);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!bus.done && cyc < 3 * LAT) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_result(input string tag, input logic [2*W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] q, r;
    logic ovf, dbz;
    ref_model(a, b, q, r, ovf, dbz);
    exp_q.push_back(q);
    chk({tag, "_done"}, 32'(bus.done), 32'd1);
    chk({tag, "_q"}, 32'(bus.quotient), 32'(exp_q.pop_front()));
    chk({tag, "_r"}, 32'(bus.remainder), 32'(r));
    chk({tag, "_ovf"}, 32'(bus.ovf), 32'(ovf));
    chk({tag, "_dbz"}, 32'(bus.dbz), 32'(dbz));
  endtask

  task automatic do_op(input string tag, input logic [2*W-1:0] a, input logic [W-1:0] b);
    int cyc;
    launch(a, b);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    wait_done(cyc);
    chk({tag, "_lat"}, 32'(cyc), 32'(LAT));
    check_result(tag, a, b);
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int cyc;
    logic saw_done;
    logic [2*W-1:0] ha, ba, bb;
    logic [W-1:0] hb, bd, bq, br;
    logic bo, bz;

    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", 32'({bus.busy, bus.done, bus.quotient, bus.remainder, bus.ovf, bus.dbz}), 32'd0);
    chk("rst_state", 32'(bus.state), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    do_op("p21_p5",  8'd21,  4'd5);
    do_op("n21_p5",  8'hEB,  4'd5);
    do_op("p21_n5",  8'd21,  4'hB);
    do_op("n21_n5",  8'hEB,  4'hB);
    do_op("p64_n8",  8'd64,  4'h8);
    do_op("p64_p7",  8'd64,  4'd7);
    do_op("dbz",     8'd37,  4'd0);
    do_op("min_n1",  8'h80,  4'hF);
    do_op("min_p1",  8'h80,  4'd1);
    do_op("min_n8",  8'h80,  4'h8);
    do_op("n1_p7",   8'hFF,  4'd7);

    // start held high with operands churning; the first capture must win
    ha = 8'hC3; hb = 4'd6;
    bus.start = 1'b1; bus.dividend = ha; bus.divisor = hb;
    @(negedge clk);
    cyc = 0;
    while (!bus.done && cyc < 3 * LAT) begin
      bus.dividend = 8'($urandom);
      bus.divisor  = 4'($urandom);
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    chk("hold_lat", 32'(cyc), 32'(LAT));
    check_result("hold", ha, hb);
    @(negedge clk);

    // Back-to-back: new start in the done cycle
    ba = 8'd100; bb = 8'hD8; bd = 4'd3;
    launch(ba, 4'd9);
    wait_done(cyc);
    chk("b2b_a_lat", 32'(cyc), 32'(LAT));
    check_result("b2b_a", ba, 4'd9);
    ref_model(ba, 4'd9, bq, br, bo, bz);
    launch(bb, bd);
    chk("b2b_hold_q", 32'(bus.quotient), 32'(bq));
    chk("b2b_b_busy", 32'(bus.busy), 32'd1);
    wait_done(cyc);
    chk("b2b_b_lat", 32'(cyc), 32'(LAT));
    check_result("b2b_b", bb, bd);
    @(negedge clk);

    // Reset during the 4th CALC cycle aborts with no done pulse
    launch(8'd77, 4'd3);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_outputs", 32'({bus.busy, bus.done, bus.quotient, bus.remainder, bus.ovf, bus.dbz}), 32'd0);
    chk("abort_state", 32'(bus.state), 32'd0);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (3 * LAT) begin
      @(negedge clk);
      if (bus.done) saw_done = 1'b1;
    end
    chk("abort_no_done", 32'(saw_done), 32'd0);
    do_op("post_abort", 8'hA5, 4'hD);

    // Randomized operands
    for (int i = 0; i < 40; i++) begin
      logic [2*W-1:0] ra;
      logic [W-1:0] rb;
      ra = 8'($urandom_range(0, 255));
      rb = (i % 5 == 4) ? 4'd0 : 4'($urandom_range(0, 15));
      do_op($sformatf("rnd%0d", i), ra, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/seq_signed_divider.md
Name: seq_signed_divider

Overview:
Sequential signed divider; the inverse of the team's combinational 4x4 Booth multiplier. It takes a 2*WIDTH-bit signed dividend (a product-width word) and a WIDTH-bit signed divisor, and returns a WIDTH-bit quotient and remainder. Quotient truncates toward zero. Overflow and divide-by-zero flags are provided. The block sits beside the multiplier in the arithmetic datapath and uses a start/busy/done handshake with fixed latency.

Parameters:
WIDTH, 4, divisor/quotient/remainder width; dividend is 2*WIDTH.

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only while idle
dividend  input  2*WIDTH  signed dividend, captured on accepted start
divisor  input  WIDTH  signed divisor, captured on accepted start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse; results valid from this cycle
quotient  output  WIDTH  signed quotient (low WIDTH bits of true quotient)
remainder  output  WIDTH  signed remainder; sign follows dividend; zero if remainder is 0
ovf  output  1  true quotient outside [-2^(WIDTH-1), 2^(WIDTH-1)-1]
dbz  output  1  divisor was zero

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: busy=0, done=0, quotient=0, remainder=0, ovf=0, dbz=0, state=IDLE. Reset has priority over everything. Asserting rst mid-operation aborts the operation; no done pulse follows.
- States:
  - IDLE: start=1 at edge t0 captures operands and sign bits. Magnitudes |dividend| (2W bits) and |divisor| (W bits, unsigned, so -2^(W-1) is representable) are loaded. Partial remainder is cleared, iteration count=0, busy<=1, next state CALC.
  - CALC: one restoring shift-subtract iteration per edge over the 2W dividend bits, MSB first. Each iteration shifts the partial remainder left by one and brings in the next dividend bit. If partial remainder >= |divisor|, subtract and set the quotient bit to 1, else set it to 0. After 2W iterations (edges t1..t2W), next state FIX.
  - FIX (edge t2W+1):
    - Negate the magnitude quotient if the operand signs differ.
    - Negate the remainder if the dividend is negative.
    - ovf = signed quotient not representable in W bits.
    - Register quotient and remainder outputs. done<=1, busy<=0, next state IDLE.
- Latency: done is high in the cycle after edge t0+2W+1, i.e. 2W+1 edges after the start edge (9 for W=4). Latency is fixed for every operand value, including dbz and ovf cases.
- done is high for exactly one cycle. Outputs hold their values until the next FIX or reset.
- start while busy: ignored; the captured operands are unchanged.
- start in the done cycle: accepted, since the state is IDLE (back-to-back operation). The outputs keep their old values until the new FIX.
- Divisor = 0: the operation runs the full latency. Outputs are dbz=1, quotient=0, remainder=0, ovf=0.
- Width rules:
  - Internal partial remainder is W+1 bits, so the subtract never loses a carry.
  - Quotient accumulator is 2W bits and is truncated to W bits at the output.
  - |remainder| < |divisor| <= 2^(W-1), so the remainder always fits in signed W bits.
- Dividend = -2^(2W-1): its magnitude is handled as unsigned 2W bits; no special case.

Decomposition:
- Shared package:
  - state enum (IDLE, CALC, FIX)
  - default WIDTH constant
  - iteration counter width, $clog2(2*WIDTH+1)
- Sub-module div_step: purely combinational single iteration.
  - Inputs: partial remainder, next dividend bit, |divisor|.
  - Outputs: new partial remainder, quotient bit.
- The top level holds the FSM, counter, sign handling and output registers.

Test Plan:
- dividend=8'sd21, divisor=4'sd5, start pulse -> done exactly 9 cycles later; quotient=4'h4, remainder=4'h1, ovf=0, dbz=0.
- Sign combinations:
  - -21/5 -> q=4'hC (-4), r=4'hF (-1)
  - 21/-5 -> q=4'hC, r=4'h1
  - -21/-5 -> q=4'h4, r=4'hF
- Multiplier round trip and overflow:
  - dividend=8'sd64 (-8*-8), divisor=-8 -> q=4'h8, r=0, ovf=0
  - dividend=64, divisor=7 -> q=4'h9 (low bits of 9), r=1, ovf=1
- divisor=0, dividend=8'sd37 -> dbz=1, q=0, r=0, ovf=0; done still 9 cycles after start.
- Handshake:
  - start held high throughout an operation with operands changing mid-run -> result matches the first captured operands.
  - New start in the done cycle -> second result appears 9 cycles later.
- Reset mid-operation: rst=1 during the 4th CALC cycle -> next edge busy=0, done=0, outputs=0; no done pulse afterwards; a subsequent start works normally.
